// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: sequential wide adder that processes one 4-bit nibble
// per clock through a single ripple-carry slice, with a one-bit carry register
// linking consecutive nibbles. Operand width is W = 4*NIBBLES (NIBBLES 2..8).
//
// Optional build macro: SERIAL_SUBTRACT_EN
//   When defined, the design has an extra 'sub' input sampled with start. With
//   sub=1 the B operand is latched inverted and the carry register is forced to
//   1, so the result is A-B (c_out=1 means no borrow).
//   When undefined, the design only adds and has no 'sub' port.

// Single-bit full adder, the building block of the nibble slice.
module nsa_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// Four-bit ripple-carry slice. The carry into bit 3 is exposed so the
// caller can form the two's-complement overflow flag on the top nibble.
module nsa_adder_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       c3,
    output logic       cout
);

    logic [4:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        nsa_full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .s    (s[i]),
            .cout (carry[i+1])
        );
    end

    assign c3   = carry[3];
    assign cout = carry[4];

endmodule

// Top level: control FSM, operand/carry registers and the shared slice.
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] a_in,
    input  logic [4*NIBBLES-1:0] b_in,
    input  logic                 c_in,
`ifdef SERIAL_SUBTRACT_EN
    input  logic                 sub,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 c_out,
    output logic                 overflow
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           state;
    logic [W-1:0]     op_a;
    logic [W-1:0]     op_b;
    logic             carry_reg;
    logic [IDX_W-1:0] nib_idx;

    logic [W-1:0]     a_shift;
    logic [W-1:0]     b_shift;
    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [3:0]       slice_sum;
    logic             slice_c3;
    logic             slice_cout;
    logic [W-1:0]     nib_placed;

    logic [W-1:0]     b_latch;
    logic             carry_latch;

    // Operand B and the initial carry as they should be captured on start;
    // subtraction is A + ~B + 1, so it only changes what gets latched.
`ifdef SERIAL_SUBTRACT_EN
    assign b_latch     = sub ? ~b_in : b_in;
    assign carry_latch = sub ? 1'b1 : c_in;
`else
    assign b_latch     = b_in;
    assign carry_latch = c_in;
`endif

    // Select the current nibble of each operand by shifting it down to bit 0.
    assign a_shift = op_a >> {nib_idx, 2'b00};
    assign b_shift = op_b >> {nib_idx, 2'b00};
    assign a_nib   = a_shift[3:0];
    assign b_nib   = b_shift[3:0];

    nsa_adder_slice u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_reg),
        .s    (slice_sum),
        .c3   (slice_c3),
        .cout (slice_cout)
    );

    // Move the slice result up to its nibble position; sum is cleared on
    // start and filled low to high, so OR-ing it in is sufficient.
    assign nib_placed = {{(W-4){1'b0}}, slice_sum} << {nib_idx, 2'b00};

    // Control FSM and all datapath registers, with registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            op_a      <= '0;
            op_b      <= '0;
            carry_reg <= 1'b0;
            nib_idx   <= '0;
            sum       <= '0;
            c_out     <= 1'b0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        op_a      <= a_in;
                        op_b      <= b_latch;
                        carry_reg <= carry_latch;
                        nib_idx   <= '0;
                        sum       <= '0;
                        busy      <= 1'b1;
                        state     <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    sum       <= sum | nib_placed;
                    carry_reg <= slice_cout;
                    if (nib_idx == LAST_IDX) begin
                        c_out    <= slice_cout;
                        overflow <= slice_c3 ^ slice_cout;
                        nib_idx  <= '0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        nib_idx <= nib_idx + 1'b1;
                    end
                end

                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Testbench for nibble_serial_adder: directed and randomized additions checked
// against a plain-arithmetic reference model of a W-bit add with carry.
// Honours SERIAL_SUBTRACT_EN when the design is built with it.
module tb_nibble_serial_adder;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         c_in;
`ifdef SERIAL_SUBTRACT_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .c_in     (c_in),
`ifdef SERIAL_SUBTRACT_EN
        .sub      (sub),
`endif
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .c_out    (c_out),
        .overflow (overflow)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    // Reference: W-bit add (or A + ~B + 1 for subtract) with carry-out and
    // signed overflow derived from operand and result sign bits.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic s,
                                  output logic [W-1:0] es, output logic ec,
                                  output logic eo);
        logic [W:0]   full;
        logic [W-1:0] bb;
        logic         cc;
        bb   = s ? ~b : b;
        cc   = s ? 1'b1 : cin;
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cc};
        es   = full[W-1:0];
        ec   = full[W];
        eo   = (a[W-1] == bb[W-1]) && (es[W-1] != a[W-1]);
    endfunction

    // Run one operation end to end; optionally wiggle inputs and hold start
    // during RUN to show the in-flight result is unaffected.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic s, input bit disturb,
                         input string tag);
        logic [W-1:0] es;
        logic         ec;
        logic         eo;
        int           busy_cycles;
        int           waited;
        bit           seen;
        model(a, b, cin, s, es, ec, eo);
        @(negedge clock);
        a_in  = a;
        b_in  = b;
        c_in  = cin;
`ifdef SERIAL_SUBTRACT_EN
        sub   = s;
`endif
        start = 1'b1;
        @(negedge clock);
        start       = disturb;
        busy_cycles = 0;
        waited      = 0;
        seen        = 1'b0;
        while (!seen && waited < 4 * NIBBLES + 8) begin
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (busy === 1'b1) busy_cycles++;
                if (disturb) begin
                    a_in = W'($urandom);
                    b_in = W'($urandom);
                    c_in = 1'($urandom_range(0, 1));
                end
                @(negedge clock);
                waited++;
            end
        end
        start = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL %s done_timeout: no done pulse within %0d cycles", tag, waited);
        end else begin
            checks++;
            if (busy_cycles !== NIBBLES) begin
                errors++;
                $display("[TB] FAIL %s busy_cycles: got %0d expected %0d", tag, busy_cycles, NIBBLES);
            end
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s busy_at_done: got %b expected 0", tag, busy);
            end
            checks++;
            if (sum !== es) begin
                errors++;
                $display("[TB] FAIL %s sum: got %h expected %h", tag, sum, es);
            end
            checks++;
            if (c_out !== ec) begin
                errors++;
                $display("[TB] FAIL %s c_out: got %b expected %b", tag, c_out, ec);
            end
            checks++;
            if (overflow !== eo) begin
                errors++;
                $display("[TB] FAIL %s overflow: got %b expected %b", tag, overflow, eo);
            end
            @(negedge clock);
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s done_width: got %b expected 0 one cycle later", tag, done);
            end
            checks++;
            if (sum !== es) begin
                errors++;
                $display("[TB] FAIL %s sum_hold: got %h expected %h", tag, sum, es);
            end
        end
    endtask

    // Outputs are all zero while reset is held.
    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        c_in  = 1'b0;
`ifdef SERIAL_SUBTRACT_EN
        sub   = 1'b0;
`endif
        repeat (3) @(negedge clock);
        checks++;
        if ({busy, done, c_out, overflow} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_flags: got busy/done/c_out/ovf=%b expected 0000",
                     {busy, done, c_out, overflow});
        end
        checks++;
        if (sum !== '0) begin
            errors++;
            $display("[TB] FAIL reset_sum: got %h expected 0000", sum);
        end
        reset = 1'b0;
    endtask

    // Directed additions including carry ripple and overflow corners.
    task automatic test_directed();
        do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, "add_basic");
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, "wrap_carry");
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, "signed_ovf");
        do_op(16'h00FF, 16'h0000, 1'b1, 1'b0, 1'b0, "cin_ripple");
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, "all_ones");
    endtask

    // Start pulsed and operands changed mid-RUN must not disturb the result.
    task automatic test_start_ignored();
        do_op(16'h1111, 16'h1111, 1'b0, 1'b0, 1'b1, "start_ignored");
    endtask

    // Reset in the second RUN cycle aborts with cleared outputs and no done.
    task automatic test_reset_mid_run();
        int done_seen;
        do_op(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0, "pre_abort");
        @(negedge clock);
        a_in  = 16'h1234;
        b_in  = 16'h4321;
        c_in  = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if ({busy, done, c_out, overflow} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL abort_flags: got busy/done/c_out/ovf=%b expected 0000",
                     {busy, done, c_out, overflow});
        end
        checks++;
        if (sum !== '0) begin
            errors++;
            $display("[TB] FAIL abort_sum: got %h expected 0000", sum);
        end
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (done === 1'b1) done_seen++;
        end
        checks++;
        if (done_seen !== 0) begin
            errors++;
            $display("[TB] FAIL abort_no_done: got %0d done cycles expected 0", done_seen);
        end
        do_op(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0, "after_abort");
    endtask

    // Randomized operands, carry, and mid-run disturbance.
    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic s;
`ifdef SERIAL_SUBTRACT_EN
            s = 1'($urandom_range(0, 1));
`else
            s = 1'b0;
`endif
            do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), s,
                  bit'($urandom_range(0, 1)), "random");
        end
    endtask

    // Consecutive operations with minimal idle time between them.
    task automatic test_back_to_back();
        do_op(16'hABCD, 16'h1234, 1'b0, 1'b0, 1'b0, "b2b_0");
        do_op(16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 1'b0, "b2b_1");
        do_op(16'h8001, 16'h8001, 1'b0, 1'b0, 1'b0, "b2b_2");
    endtask

`ifdef SERIAL_SUBTRACT_EN
    // Subtraction: borrow and no-borrow cases, c_in ignored.
    task automatic test_subtract();
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, "sub_borrow");
        do_op(16'h0009, 16'h0002, 1'b1, 1'b1, 1'b0, "sub_noborrow");
        do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, "sub_ovf");
    endtask
`endif

    // Test sequence and summary.
    initial begin
        $display("[TB] starting nibble_serial_adder bench, NIBBLES=%0d", NIBBLES);
        test_reset();
        test_directed();
        test_start_ignored();
        test_reset_mid_run();
`ifdef SERIAL_SUBTRACT_EN
        test_subtract();
`endif
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
